// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command sequencer for an external 4-bit universal shift register
//
// Purpose: accepts a shift command (parallel-in/serial-out right or left,
// serial capture right, rotate right) and drives the mode, parallel and
// serial inputs of a 74194-style register. Each command runs through
// IDLE -> LOAD -> SHIFT (COUNT cycles) -> FIN.
//
// Ports:
//   CLK            clock, rising edge active
//   CLR            asynchronous active-low reset
//   START          command request, sampled only in IDLE
//   CMD[1:0]       00 PISO-right, 01 PISO-left, 10 capture-right, 11 rotate-right
//   COUNT[2:0]     number of shift cycles (0..7)
//   DIN[3:0]       parallel word {A,B,C,D}
//   SER_IN         serial data for capture
//   PAUSE          freezes shifting while high (SHIFT only)
//   ABORT          cancels the command in LOAD/SHIFT
//   QA, QD         register taps
//   S1, S0         register mode (00 hold, 01 right, 10 left, 11 load)
//   PA..PD         register parallel inputs
//   SR_OUT, SL_OUT register right/left serial inputs
//   TX_BIT         bit leaving the register, TX_VALID its qualifier
//   BUSY           command in progress (LOAD, SHIFT, FIN)
//   DONE           one-cycle completion pulse (FIN)
module shift_seq_ctrl (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic [1:0] CMD,
  input  logic [2:0] COUNT,
  input  logic [3:0] DIN,
  input  logic       SER_IN,
  input  logic       PAUSE,
  input  logic       ABORT,
  input  logic       QA,
  input  logic       QD,
  output logic       S1,
  output logic       S0,
  output logic       PA,
  output logic       PB,
  output logic       PC,
  output logic       PD,
  output logic       SR_OUT,
  output logic       SL_OUT,
  output logic       TX_BIT,
  output logic       TX_VALID,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  localparam logic [1:0] CMD_PISO_R = 2'b00;
  localparam logic [1:0] CMD_PISO_L = 2'b01;
  localparam logic [1:0] CMD_CAPT_R = 2'b10;
  localparam logic [1:0] CMD_ROT_R  = 2'b11;

  state_t     state;
  logic [1:0] cmd_q;
  logic [2:0] rem;
  logic [3:0] word_q;

  // Sequencing state plus the BUSY/DONE flags, all registered together so
  // the flags always agree with the state they describe.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state  <= IDLE;
      cmd_q  <= 2'b00;
      rem    <= 3'd0;
      word_q <= 4'b0000;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            cmd_q  <= CMD;
            rem    <= COUNT;
            // Capture starts from an empty register so only SER_IN bits land in it.
            word_q <= (CMD == CMD_CAPT_R) ? 4'b0000 : DIN;
            state  <= LOAD;
            BUSY   <= 1'b1;
          end
        end
        LOAD: begin
          if (ABORT) begin
            state <= IDLE;
            rem   <= 3'd0;
            BUSY  <= 1'b0;
          end else if (rem != 3'd0) begin
            state <= SHIFT;
          end else begin
            state <= FIN;
            DONE  <= 1'b1;
          end
        end
        SHIFT: begin
          // ABORT wins over PAUSE.
          if (ABORT) begin
            state <= IDLE;
            rem   <= 3'd0;
            BUSY  <= 1'b0;
          end else if (!PAUSE) begin
            rem <= rem - 3'd1;
            if (rem == 3'd1) begin
              state <= FIN;
              DONE  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Register controls depend on live PAUSE, SER_IN and the register taps,
  // so they are decoded combinationally from the registered state.
  always_comb begin
    {S1, S0}         = 2'b00;
    {PA, PB, PC, PD} = 4'b0000;
    SR_OUT           = 1'b0;
    SL_OUT           = 1'b0;
    TX_BIT           = 1'b0;
    TX_VALID         = 1'b0;
    case (state)
      LOAD: begin
        {S1, S0}         = 2'b11;
        {PA, PB, PC, PD} = word_q;
      end
      SHIFT: begin
        case (cmd_q)
          CMD_CAPT_R: SR_OUT = SER_IN;
          CMD_ROT_R:  SR_OUT = QD;
          default:    SR_OUT = 1'b0;
        endcase
        if (!PAUSE) begin
          {S1, S0} = (cmd_q == CMD_PISO_L) ? 2'b10 : 2'b01;
          TX_VALID = 1'b1;
          // Left shifts push bits out of QA; everything else leaves via QD.
          TX_BIT   = (cmd_q == CMD_PISO_L) ? QA : QD;
        end
      end
      default: begin
        {S1, S0} = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl with a modelled 4-bit register
module tb_shift_seq_ctrl;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       START;
  logic [1:0] CMD;
  logic [2:0] COUNT;
  logic [3:0] DIN;
  logic       SER_IN;
  logic       PAUSE;
  logic       ABORT;
  logic       QA, QD;
  logic       S1, S0, PA, PB, PC, PD, SR_OUT, SL_OUT, TX_BIT, TX_VALID, BUSY, DONE;

  logic [3:0]  mreg = 4'b0000;
  logic [11:0] outs;
  bit          sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  shift_seq_ctrl dut (
    .CLK(CLK), .CLR(CLR), .START(START), .CMD(CMD), .COUNT(COUNT), .DIN(DIN),
    .SER_IN(SER_IN), .PAUSE(PAUSE), .ABORT(ABORT), .QA(QA), .QD(QD),
    .S1(S1), .S0(S0), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .SR_OUT(SR_OUT), .SL_OUT(SL_OUT), .TX_BIT(TX_BIT), .TX_VALID(TX_VALID),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // External universal shift register, word held as {QA,QB,QC,QD}.
  assign QA = mreg[3];
  assign QD = mreg[0];
  always @(posedge CLK) begin
    case ({S1, S0})
      2'b01:   mreg <= {SR_OUT, mreg[3:1]};
      2'b10:   mreg <= {mreg[2:0], SL_OUT};
      2'b11:   mreg <= {PA, PB, PC, PD};
      default: mreg <= mreg;
    endcase
  end

  assign outs = {S1, S0, PA, PB, PC, PD, SR_OUT, SL_OUT, TX_BIT, TX_VALID, BUSY, DONE};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one command. pause_at is the shift index where PAUSE starts (held
  // pause_len cycles), abort_at the cycle number (1 = LOAD) carrying ABORT.
  task automatic run_cmd(input logic [1:0] cmd, input logic [2:0] cnt, input logic [3:0] din,
                         input logic [7:0] ser, input int pause_at, input int pause_len,
                         input int abort_at, input bit hold_start);
    logic [3:0] ld;
    logic [3:0] w;
    logic [1:0] exp_mode;
    bit         e;
    bit         p;
    bit         aborted;
    bit         finished;
    int         sd;
    int         pc;

    ld = (cmd == 2'b10) ? 4'b0000 : din;
    w  = ld;
    for (int i = 0; i < int'(cnt); i++) begin
      case (cmd)
        2'b00: begin sb.push_back(w[0]); w = {1'b0, w[3:1]}; end
        2'b01: begin sb.push_back(w[3]); w = {w[2:0], 1'b0}; end
        2'b10: begin sb.push_back(w[0]); w = {ser[i], w[3:1]}; end
        default: begin sb.push_back(w[0]); w = {w[0], w[3:1]}; end
      endcase
    end

    @(negedge CLK);
    START = 1'b1; CMD = cmd; COUNT = cnt; DIN = din; PAUSE = 1'b0; ABORT = 1'b0;
    #1;
    chk("idle_busy", 32'(BUSY), 32'(0));

    @(negedge CLK);
    START = hold_start;
    if (hold_start) begin CMD = ~cmd; COUNT = ~cnt; DIN = ~din; end
    ABORT = (abort_at == 1);
    #1;
    chk("load_mode", 32'({S1, S0}), 32'(2'b11));
    chk("load_word", 32'({PA, PB, PC, PD}), 32'(ld));
    chk("load_busy", 32'(BUSY), 32'(1));
    chk("load_done", 32'(DONE), 32'(0));

    aborted = ABORT; finished = 1'b0; sd = 0; pc = 0;
    for (int c = 2; c < 40 && !finished; c++) begin
      @(negedge CLK);
      if (aborted) begin
        ABORT = 1'b0; START = 1'b0;
        #1;
        chk("abort_idle", 32'({BUSY, DONE, S1, S0, TX_VALID}), 32'(0));
        finished = 1'b1;
      end else begin
        START = hold_start;
        p = (sd == pause_at) && (pc < pause_len);
        PAUSE = p;
        SER_IN = ser[sd];
        ABORT = (c == abort_at);
        #1;
        if (sd < int'(cnt)) begin
          exp_mode = p ? 2'b00 : ((cmd == 2'b01) ? 2'b10 : 2'b01);
          chk("shift_mode", 32'({S1, S0}), 32'(exp_mode));
          chk("shift_txv", 32'(TX_VALID), 32'(!p));
          chk("shift_busy_done", 32'({BUSY, DONE}), 32'(2'b10));
          if (!p) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
            e = (sb.size() != 0) ? sb.pop_front() : 1'b0;
            chk("tx_bit", 32'(TX_BIT), 32'(e));
            if (cmd == 2'b10) chk("sr_pass", 32'(SR_OUT), 32'(SER_IN));
            sd++;
          end else begin
            chk("pause_tx_p", 32'({TX_BIT, PA, PB, PC, PD}), 32'(0));
            pc++;
          end
          aborted = ABORT;
        end else begin
          chk("fin_done", 32'(DONE), 32'(1));
          chk("fin_cycle", 32'(c), 32'(int'(cnt) + 2 + pc));
          chk("fin_outs", 32'({S1, S0, PA, PB, PC, PD, TX_VALID, TX_BIT, BUSY}), 32'(1));
          finished = 1'b1;
        end
      end
    end
    if (!finished) chk("cycle_budget", 32'(0), 32'(1));

    START = 1'b0; PAUSE = 1'b0; ABORT = 1'b0;
    if (aborted) begin
      sb.delete();
    end else begin
      chk("final_reg", 32'(mreg), 32'(w));
      chk("sb_empty", 32'(sb.size()), 32'(0));
    end

    @(negedge CLK);
    #1;
    chk("post_idle", 32'({BUSY, DONE, S1, S0, TX_VALID}), 32'(0));
  endtask

  initial begin
    CLR = 1'b0; START = 1'b0; CMD = 2'b00; COUNT = 3'd0; DIN = 4'b0000;
    SER_IN = 1'b0; PAUSE = 1'b0; ABORT = 1'b0;
    #3;
    chk("reset_outs", 32'(outs), 32'(0));
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b1;

    // PISO right, 1011 x4: TX 1,1,0,1, register empties
    run_cmd(2'b00, 3'd4, 4'b1011, 8'h00, -1, 0, -1, 1'b0);
    // capture right, SER_IN 1,0,0,1 -> 1001
    run_cmd(2'b10, 3'd4, 4'b1111, 8'b0000_1001, -1, 0, -1, 1'b0);
    // rotate 0001 once -> 1000; left 1000 once -> TX 1, 0000
    run_cmd(2'b11, 3'd1, 4'b0001, 8'h00, -1, 0, -1, 1'b0);
    run_cmd(2'b01, 3'd1, 4'b1000, 8'h00, -1, 0, -1, 1'b0);
    // COUNT=0 with START held through the whole command
    run_cmd(2'b00, 3'd0, 4'b1111, 8'h00, -1, 0, -1, 1'b1);
    // long counts push fill bits through
    run_cmd(2'b00, 3'd6, 4'b1011, 8'h00, -1, 0, -1, 1'b0);
    run_cmd(2'b01, 3'd5, 4'b1101, 8'h00, -1, 0, -1, 1'b1);
    run_cmd(2'b11, 3'd7, 4'b0110, 8'h00, -1, 0, -1, 1'b0);
    run_cmd(2'b10, 3'd7, 4'b0000, 8'b0101_1011, -1, 0, -1, 1'b0);
    // two-cycle pause mid-shift
    run_cmd(2'b00, 3'd4, 4'b1101, 8'h00, 2, 2, -1, 1'b0);
    // aborts: in SHIFT, in LOAD, and while paused
    run_cmd(2'b01, 3'd5, 4'b1011, 8'h00, -1, 0, 3, 1'b0);
    run_cmd(2'b11, 3'd3, 4'b1001, 8'h00, -1, 0, 1, 1'b0);
    run_cmd(2'b00, 3'd4, 4'b0111, 8'h00, 1, 2, 3, 1'b0);

    // asynchronous reset in the middle of a shift
    @(negedge CLK);
    START = 1'b1; CMD = 2'b00; COUNT = 3'd5; DIN = 4'b1111;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2;
    CLR = 1'b0;
    #1;
    chk("clr_async", 32'(outs), 32'(0));
    @(negedge CLK);
    #1;
    chk("clr_hold", 32'(outs), 32'(0));
    CLR = 1'b1;
    sb.delete();
    run_cmd(2'b11, 3'd4, 4'b1001, 8'h00, -1, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
